// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running raster counters for the drawing logic, plus
// sync and pixel outputs re-aligned to the drawing logic's return latency.
module vga_timing_gen #(
  parameter int DISP_COLS        = 800,
  parameter int DISP_ROWS        = 600,
  parameter int H_FRONT          = 56,
  parameter int H_SYNC           = 120,
  parameter int H_BACK           = 64,
  parameter int V_FRONT          = 37,
  parameter int V_SYNC           = 6,
  parameter int V_BACK           = 23,
  parameter int SYNC_ACTIVE_HIGH = 1,
  parameter int RGB_LATENCY      = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rgb_in,
  output logic [11:0] col_counter,
  output logic [11:0] row_counter,
  output logic        video_on,
  output logic        frame_tick,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  rgb_out
);

  localparam int H_TOTAL = DISP_COLS + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = DISP_ROWS + V_FRONT + V_SYNC + V_BACK;

  // Bounds are 13 bits wide so a total of exactly 4096 still compares cleanly.
  localparam logic [11:0] H_LAST       = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST       = 12'(V_TOTAL - 1);
  localparam logic [12:0] H_VIS        = 13'(DISP_COLS);
  localparam logic [12:0] V_VIS        = 13'(DISP_ROWS);
  localparam logic [12:0] H_SYNC_START = 13'(DISP_COLS + H_FRONT);
  localparam logic [12:0] H_SYNC_END   = 13'(DISP_COLS + H_FRONT + H_SYNC);
  localparam logic [12:0] V_SYNC_START = 13'(DISP_ROWS + V_FRONT);
  localparam logic [12:0] V_SYNC_END   = 13'(DISP_ROWS + V_FRONT + V_SYNC);
  localparam logic        SYNC_ON      = (SYNC_ACTIVE_HIGH != 0);

  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
  end

  if (RGB_LATENCY < 0 || RGB_LATENCY > 4) begin : g_bad_latency
    $error("vga_timing_gen: RGB_LATENCY must be in 0..4");
  end

  logic [11:0] col_next;
  logic [11:0] row_next;
  logic        h_raw;
  logic        v_raw;
  logic [2:0]  flags_now;
  logic [2:0]  flags_dly;

  // Next raster position: column wraps every line, row wraps on the last column of the last line.
  always_comb begin
    col_next = col_counter + 12'd1;
    row_next = row_counter;
    if (col_counter == H_LAST) begin
      col_next = '0;
      row_next = (row_counter == V_LAST) ? 12'd0 : row_counter + 12'd1;
    end
  end

  // Counters and the flags describing them; flags come from the next position so they line up with the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_counter <= '0;
      row_counter <= '0;
      video_on    <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      col_counter <= col_next;
      row_counter <= row_next;
      video_on    <= ({1'b0, col_next} < H_VIS) && ({1'b0, row_next} < V_VIS);
      frame_tick  <= (col_next == 12'd0) && ({1'b0, row_next} == V_VIS);
    end
  end

  // Raw sync windows, decoded straight from the current counters; vsync depends on row only.
  always_comb begin
    h_raw = ({1'b0, col_counter} >= H_SYNC_START) && ({1'b0, col_counter} < H_SYNC_END);
    v_raw = ({1'b0, row_counter} >= V_SYNC_START) && ({1'b0, row_counter} < V_SYNC_END);
    flags_now = {h_raw, v_raw, video_on};
  end

  if (RGB_LATENCY == 0) begin : g_no_delay
    assign flags_dly = flags_now;
  end else begin : g_delay
    logic [2:0] stage [RGB_LATENCY];

    // Shift the sync/visible flags along so they meet the pixel that belongs to them.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < RGB_LATENCY; i++) begin
          stage[i] <= '0;
        end
      end else begin
        stage[0] <= flags_now;
        for (int i = 1; i < RGB_LATENCY; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign flags_dly = stage[RGB_LATENCY-1];
  end

  // Pin register: blank the pixel outside the visible area and map sync to the panel polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync   <= ~SYNC_ON;
      vsync   <= ~SYNC_ON;
      rgb_out <= '0;
    end else begin
      hsync   <= flags_dly[2] ? SYNC_ON : ~SYNC_ON;
      vsync   <= flags_dly[1] ? SYNC_ON : ~SYNC_ON;
      rgb_out <= flags_dly[0] ? rgb_in : 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random pixels into a reduced-size raster; a positional
// reference model predicts every pin each cycle and a monitor compares them.
module tb_vga_timing_gen;

  // A small raster keeps several whole frames within a short run.
  localparam int DC  = 16;
  localparam int HF  = 3;
  localparam int HS  = 4;
  localparam int HB  = 2;
  localparam int DR  = 10;
  localparam int VF  = 2;
  localparam int VS  = 3;
  localparam int VB  = 2;
  localparam int LAT = 2;
  localparam int SAH = 0;
  localparam int HT  = DC + HF + HS + HB;
  localparam int VT  = DR + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic ACT = (SAH != 0);

  typedef struct {
    logic [11:0] col;
    logic [11:0] row;
    logic        von;
    logic        ft;
    logic        hs;
    logic        vs;
    logic [7:0]  rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rgb_in = 8'h00;
  logic [11:0] col_counter;
  logic [11:0] row_counter;
  logic        video_on;
  logic        frame_tick;
  logic        hsync;
  logic        vsync;
  logic [7:0]  rgb_out;

  int   checks = 0;
  int   errors = 0;
  int   edgeCount = 0;
  exp_t expQ[$];

  vga_timing_gen #(
    .DISP_COLS(DC), .DISP_ROWS(DR),
    .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_HIGH(SAH), .RGB_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rgb_in(rgb_in),
    .col_counter(col_counter),
    .row_counter(row_counter),
    .video_on(video_on),
    .frame_tick(frame_tick),
    .hsync(hsync),
    .vsync(vsync),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  // Expected pins after the m-th rising edge since reset release, given the
  // pixel the drawing logic presented just before that edge.
  function automatic exp_t modelAt(input int m, input logic [7:0] rgbNow);
    exp_t e;
    int p, c, r, k, kc, kr;
    p = m % FRAME;
    c = p % HT;
    r = p / HT;
    e.col = 12'(c);
    e.row = 12'(r);
    e.von = (c < DC) && (r < DR);
    e.ft  = (c == 0) && (r == DR);
    // The pins show the raster position from LAT+1 edges ago; before the
    // first counted position everything is still blank and inactive.
    k = m - 1 - LAT;
    if (k < 1) begin
      e.hs  = ~ACT;
      e.vs  = ~ACT;
      e.rgb = 8'h00;
    end else begin
      kc = (k % FRAME) % HT;
      kr = (k % FRAME) / HT;
      e.hs  = (kc >= DC + HF && kc < DC + HF + HS) ? ACT : ~ACT;
      e.vs  = (kr >= DR + VF && kr < DR + VF + VS) ? ACT : ~ACT;
      e.rgb = (kc < DC && kr < DR) ? rgbNow : 8'h00;
    end
    return e;
  endfunction

  function automatic exp_t resetValues();
    exp_t e;
    e.col = '0;
    e.row = '0;
    e.von = 1'b0;
    e.ft  = 1'b0;
    e.hs  = ~ACT;
    e.vs  = ~ACT;
    e.rgb = 8'h00;
    return e;
  endfunction

  // Compare one field and log it if it disagrees.
  task automatic checkField(input string tag, input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s %s got %0d want %0d (t=%0t)", tag, name, got, want, $time);
    end
  endtask

  // Compare every output pin against one expected record.
  task automatic checkOutput(input exp_t e, input string tag);
    checkField(tag, "col_counter", int'(col_counter), int'(e.col));
    checkField(tag, "row_counter", int'(row_counter), int'(e.row));
    checkField(tag, "video_on",    int'(video_on),    int'(e.von));
    checkField(tag, "frame_tick",  int'(frame_tick),  int'(e.ft));
    checkField(tag, "hsync",       int'(hsync),       int'(e.hs));
    checkField(tag, "vsync",       int'(vsync),       int'(e.vs));
    checkField(tag, "rgb_out",     int'(rgb_out),     int'(e.rgb));
  endtask

  // Drive a random pixel each cycle and queue what the pins should show after the next edge.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      edgeCount++;
      rgb_in = 8'($urandom);
      expQ.push_back(modelAt(edgeCount, rgb_in));
      @(negedge clk);
    end
  endtask

  // Monitor: just after each rising edge, consume one queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e, "scan");
      end
    end
  end

  // Main sequence: reset, several frames, a mid-frame reset, then a restart.
  initial begin
    #1 rst_n = 1'b0;
    #1 checkOutput(resetValues(), "reset_async");
    repeat (5) begin
      @(negedge clk);
      checkOutput(resetValues(), "reset_hold");
    end

    rst_n = 1'b1;
    edgeCount = 0;
    applyStimulus(2 * FRAME + 3 * HT + 7);

    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 checkOutput(resetValues(), "midframe_reset");
    repeat (3) begin
      @(negedge clk);
      checkOutput(resetValues(), "midframe_hold");
    end

    rst_n = 1'b1;
    edgeCount = 0;
    applyStimulus(FRAME + 11);

    @(posedge clk);
    #2;
    checkField("end", "queue_drained", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster scan that feeds the object-drawing logic.
- Free-running column/row counters go to the drawing logic, which returns an 8-bit rgb pixel a fixed number of cycles later.
- This block aligns hsync/vsync with that returned pixel, blanks it outside the visible area, and drives the display pins.
- Also emits a once-per-frame tick at the start of vertical blanking, used to step paddle and ball motion.

Parameters:
- DISP_COLS, 800: visible columns
- DISP_ROWS, 600: visible rows
- H_FRONT, 56: horizontal front porch, in pixels
- H_SYNC, 120: hsync pulse width, in pixels
- H_BACK, 64: horizontal back porch, in pixels
- V_FRONT, 37: vertical front porch, in lines
- V_SYNC, 6: vsync pulse width, in lines
- V_BACK, 23: vertical back porch, in lines
- SYNC_ACTIVE_HIGH, 1: 1 means the sync pulse drives 1; 0 means the sync pulse drives 0
- RGB_LATENCY, 1: clocks from col_counter/row_counter to the matching rgb_in; range 0..4

Ports:
- clk, input, 1: pixel clock, 50 MHz for the default 800x600@72 timing
- rst_n, input, 1: asynchronous, active-low reset
- rgb_in, input, 8: pixel from the drawing logic, valid RGB_LATENCY clocks after its counters
- col_counter, output, 12: current column, 0..H_TOTAL-1
- row_counter, output, 12: current row, 0..V_TOTAL-1
- video_on, output, 1: counters are inside the visible area; aligned with the counters
- frame_tick, output, 1: one-clock pulse at the start of vertical blanking; aligned with the counters
- hsync, output, 1: horizontal sync, delayed to align with rgb_out
- vsync, output, 1: vertical sync, delayed to align with rgb_out
- rgb_out, output, 8: blanked pixel to the display DAC

Behaviour:
- Derived totals:
  - H_TOTAL = DISP_COLS + H_FRONT + H_SYNC + H_BACK (1040 by default)
  - V_TOTAL = DISP_ROWS + V_FRONT + V_SYNC + V_BACK (666 by default)
- Reset (rst_n low, asynchronous):
  - col_counter = 0, row_counter = 0
  - video_on = 0, frame_tick = 0
  - hsync and vsync = inactive level (!SYNC_ACTIVE_HIGH)
  - rgb_out = 0
  - All delay-line stages cleared to inactive sync / blank
  - Deassertion is synchronous to clk (external synchroniser). First count occurs on the first rising edge after release.
- Counters:
  - col_counter increments every clock.
  - At H_TOTAL-1 it wraps to 0 and row_counter increments.
  - row_counter wraps from V_TOTAL-1 to 0 on the same edge col wraps.
  - No enable input; counting never stalls.
- Counter-aligned flags, registered so they are valid in the same cycle as the counter value they describe:
  - video_on = (col < DISP_COLS) && (row < DISP_ROWS)
  - frame_tick = 1 exactly when col == 0 && row == DISP_ROWS; one clock per frame.
- Raw sync, computed from the counters:
  - h_raw active when DISP_COLS+H_FRONT <= col < DISP_COLS+H_FRONT+H_SYNC
  - v_raw active when DISP_ROWS+V_FRONT <= row < DISP_ROWS+V_FRONT+V_SYNC
  - vsync is line-granular: it changes only with row, never mid-line.
- Alignment pipeline:
  - {h_raw, v_raw, video_on} pass through a shift register RGB_LATENCY deep.
  - Output stage is one register: rgb_out = delayed_video_on ? rgb_in : 0.
  - hsync/vsync = delayed raw value mapped to polarity.
  - Pin latency from counters is therefore RGB_LATENCY+1 clocks for all three outputs.
  - With RGB_LATENCY = 0 there is no shift register, only the output register.
- Boundary cases:
  - rgb_in nonzero during blanking: rgb_out must be 0.
  - Col wrap and row wrap occur on the same edge at (H_TOTAL-1, V_TOTAL-1) -> (0, 0).
  - Mid-frame reset: all outputs return to reset values immediately. The scan restarts at (0, 0) on release with no partial-frame frame_tick.
- Arithmetic:
  - All comparisons are unsigned 12-bit.
  - Parameters must satisfy H_TOTAL, V_TOTAL <= 4096. Checked by an elaboration-time assertion.

Test Plan:
1. Reset release: hold rst_n low for 5 clocks, then release -> counters 0, rgb_out 0, hsync/vsync inactive during reset; col_counter reads 1 on the first edge after release.
2. Line timing: run one line with defaults -> col wraps 1039 -> 0 and row increments 0 -> 1. With RGB_LATENCY = 1, hsync is active for exactly 120 clocks, starting 2 clocks after col_counter = 856.
3. Frame timing: run one full frame (1040 x 666 = 692640 clocks).
   - frame_tick pulses exactly once, in the cycle with col = 0, row = 600.
   - vsync is active for 6 x 1040 = 6240 clocks, starting at row 637 (+2-clock alignment).
4. Blanking: drive rgb_in = 8'hFF constantly -> rgb_out = FF for exactly 800 consecutive clocks per visible line; 0 during horizontal blank and for all of rows 600..665.
5. Latency/polarity sweep: RGB_LATENCY = 0 and 3, SYNC_ACTIVE_HIGH = 0.
   - Drive rgb_in = col_counter[7:0] delayed by RGB_LATENCY -> rgb_out at the first visible pixel equals 8'h00, and at pixel 5 equals 8'h05.
   - Sync pulses are low-active with the same widths as in scenarios 2 and 3.
6. Mid-frame reset: assert rst_n at row 300, col 400 for 3 clocks -> outputs are at reset values asynchronously; after release the scan restarts from (0, 0) and the next frame_tick occurs 600 x 1040 clocks later.
